// File: rtl/dmem_arb_pkg.sv
// Shared types and default parameters for the data-memory arbiter.
package dmem_arb_pkg;
    localparam int unsigned STARVE_MAX_DEF = 4;
    localparam int unsigned ADDR_W_DEF     = 5;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {OWN_A, OWN_B} owner_t;
endpackage

// File: rtl/data_mem_arbiter_if.sv
// Request/response bundle for both requester ports plus the external memory bus.
interface data_mem_arbiter_if import dmem_arb_pkg::*; #(
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    logic              a_req, a_we, a_ready, a_err;
    logic [31:0]       a_addr, a_wdata, a_rdata;
    logic              b_req, b_we, b_ready, b_err;
    logic [31:0]       b_addr, b_wdata, b_rdata;
    logic              stall;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_rdata, a_ready, a_err, stall,
        input  b_req, b_we, b_addr, b_wdata,
        output b_rdata, b_ready, b_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_rdata, a_ready, a_err, stall,
        output b_req, b_we, b_addr, b_wdata,
        input  b_rdata, b_ready, b_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_addr_check.sv
// Byte address to word index translation with alignment/range fault detection.
module dmem_addr_check import dmem_arb_pkg::*; #(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [31:0]       addr,
    output logic [ADDR_W-1:0] word_idx,
    output logic              fault
);
    always_comb begin
        word_idx = addr[ADDR_W+1:2];
        fault    = (addr[1:0] != 2'b00) || (addr[31:ADDR_W+2] != '0);
    end
endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter (pipeline port A, loader port B) in front of a single-port
// synchronous-read data memory; A has priority with a bounded starvation guard for B.
module data_mem_arbiter import dmem_arb_pkg::*; #(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF
) (
    input logic               clk,
    input logic               rst,
    data_mem_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    state_t            state_q, state_d;
    owner_t            owner_q;
    logic              we_q, fault_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [ADDR_W-1:0] a_idx, b_idx;
    logic              a_fault, b_fault;
    logic              grant_a, grant_b;
    logic [31:0]       resp_data;

    dmem_addr_check #(.ADDR_W(ADDR_W)) u_chk_a (
        .addr(bus.a_addr), .word_idx(a_idx), .fault(a_fault)
    );
    dmem_addr_check #(.ADDR_W(ADDR_W)) u_chk_b (
        .addr(bus.b_addr), .word_idx(b_idx), .fault(b_fault)
    );

    // B takes the slot only once A has won STARVE_MAX times in a row against it.
    always_comb begin
        grant_a = bus.a_req && !(bus.b_req && (cnt_q == CNT_MAX));
        grant_b = !grant_a && bus.b_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_A;
            we_q    <= 1'b0;
            fault_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (grant_a) begin
                    owner_q <= OWN_A;
                    we_q    <= bus.a_we;
                    fault_q <= a_fault;
                    idx_q   <= a_idx;
                    wdata_q <= bus.a_wdata;
                    if (bus.b_req && (cnt_q != CNT_MAX))
                        cnt_q <= cnt_q + 1'b1;
                end else if (grant_b) begin
                    owner_q <= OWN_B;
                    we_q    <= bus.b_we;
                    fault_q <= b_fault;
                    idx_q   <= b_idx;
                    wdata_q <= bus.b_wdata;
                    cnt_q   <= '0;
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.a_ready   = 1'b0;
        bus.b_ready   = 1'b0;
        case (state_q)
            IDLE: if (bus.a_req || bus.b_req) state_d = ACCESS;
            ACCESS: begin
                state_d = RESP;
                if (!fault_q && !rst) begin
                    bus.mem_en    = 1'b1;
                    bus.mem_we    = we_q;
                    bus.mem_addr  = idx_q;
                    bus.mem_wdata = wdata_q;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (!rst) begin
                    bus.a_ready = (owner_q == OWN_A);
                    bus.b_ready = (owner_q == OWN_B);
                end
            end
            default: state_d = IDLE;
        endcase
        resp_data   = (!we_q && !fault_q) ? bus.mem_rdata : '0;
        bus.a_rdata = bus.a_ready ? resp_data : '0;
        bus.b_rdata = bus.b_ready ? resp_data : '0;
        bus.a_err   = bus.a_ready && fault_q;
        bus.b_err   = bus.b_ready && fault_q;
        bus.stall   = bus.a_req && !bus.a_ready && !rst;
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with a behavioural 32-word memory.
module tb_data_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    data_mem_arbiter_if #(.ADDR_W(5)) bus ();

    data_mem_arbiter #(.STARVE_MAX(4), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] tbmem [32];
    logic [31:0] rd_q;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) tbmem[bus.mem_addr] <= bus.mem_wdata;
            else            rd_q <= tbmem[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = rd_q;

    function automatic logic [31:0] pat(input int unsigned i);
        logic [7:0] b;
        b = 8'(i);
        return {8'hC3, b, ~b, 8'h3C};
    endfunction

    // Issues one request on the chosen port and reports what the DUT did.
    task automatic run_txn(input logic port_b, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                           output logic err, output logic en_seen, output logic we_seen,
                           output logic [4:0] maddr, output logic stall_bad);
        logic rdy;
        @(negedge clk);
        if (port_b) begin
            bus.b_req = 1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
        end else begin
            bus.a_req = 1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
        end
        lat = -1; rdata = '0; err = 0; en_seen = 0; we_seen = 0; maddr = '0; stall_bad = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.mem_en) begin
                en_seen = 1; we_seen = bus.mem_we; maddr = bus.mem_addr;
            end
            rdy = port_b ? bus.b_ready : bus.a_ready;
            if (bus.stall !== (port_b ? 1'b0 : !rdy)) stall_bad = 1;
            if (rdy) begin
                lat = i;
                rdata = port_b ? bus.b_rdata : bus.a_rdata;
                err   = port_b ? bus.b_err : bus.a_err;
                break;
            end
        end
        bus.a_req = 0; bus.b_req = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1; bus.a_req = 1; bus.a_addr = 32'h8; bus.b_req = 1; bus.b_addr = 32'h0;
        repeat (3) @(negedge clk);
        total++; if (bus.a_ready !== 0) begin bad++; $display("FAIL rst_a_ready got=%b exp=0", bus.a_ready); end
        total++; if (bus.b_ready !== 0) begin bad++; $display("FAIL rst_b_ready got=%b exp=0", bus.b_ready); end
        total++; if (bus.mem_en !== 0) begin bad++; $display("FAIL rst_mem_en got=%b exp=0", bus.mem_en); end
        total++; if (bus.mem_we !== 0) begin bad++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); end
        total++; if (bus.stall !== 0) begin bad++; $display("FAIL rst_stall got=%b exp=0", bus.stall); end
        total++; if (bus.a_rdata !== 0) begin bad++; $display("FAIL rst_a_rdata got=%h exp=0", bus.a_rdata); end
        total++; if (dut.cnt_q !== 0) begin bad++; $display("FAIL rst_starve got=%0d exp=0", dut.cnt_q); end
        bus.a_req = 0; bus.b_req = 0; rst = 0;
        repeat (2) @(negedge clk);
        total++; if (bus.mem_en !== 0) begin bad++; $display("FAIL idle_mem_en got=%b exp=0", bus.mem_en); end
    endtask

    task automatic test_a_store_load();
        int lat; logic [31:0] rd; logic err, en, we, sb; logic [4:0] ma;
        run_txn(0, 1, 32'h8, 32'hDEADBEEF, lat, rd, err, en, we, ma, sb);
        total++; if (lat !== 2) begin bad++; $display("FAIL st_latency got=%0d exp=2", lat); end
        total++; if (en !== 1 || we !== 1) begin bad++; $display("FAIL st_strobes got=%b%b exp=11", en, we); end
        total++; if (ma !== 5'd2) begin bad++; $display("FAIL st_mem_addr got=%0d exp=2", ma); end
        total++; if (rd !== 0 || err !== 0) begin bad++; $display("FAIL st_resp got=%h/%b exp=0/0", rd, err); end
        total++; if (sb !== 0) begin bad++; $display("FAIL st_stall got=%b exp=0", sb); end
        total++; if (tbmem[2] !== 32'hDEADBEEF) begin bad++; $display("FAIL st_word got=%h exp=deadbeef", tbmem[2]); end
        run_txn(0, 0, 32'h8, 32'h0, lat, rd, err, en, we, ma, sb);
        total++; if (lat !== 2) begin bad++; $display("FAIL ld_latency got=%0d exp=2", lat); end
        total++; if (en !== 1 || we !== 0 || ma !== 5'd2) begin bad++; $display("FAIL ld_strobes got=%b%b/%0d exp=10/2", en, we, ma); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL ld_rdata got=%h exp=deadbeef", rd); end
        total++; if (err !== 0 || sb !== 0) begin bad++; $display("FAIL ld_err_stall got=%b%b exp=00", err, sb); end
        @(negedge clk);
        total++; if (bus.a_rdata !== 0 || bus.a_ready !== 0) begin bad++; $display("FAIL ld_idle_rdata got=%h exp=0", bus.a_rdata); end
    endtask

    task automatic test_fault();
        int lat; logic [31:0] rd; logic err, en, we, sb; logic [4:0] ma;
        logic [31:0] addrs [2];
        addrs[0] = 32'h6; addrs[1] = 32'h80;
        for (int k = 0; k < 2; k++) begin
            run_txn(0, 0, addrs[k], 32'h0, lat, rd, err, en, we, ma, sb);
            total++; if (lat !== 2) begin bad++; $display("FAIL flt_latency addr=%h got=%0d exp=2", addrs[k], lat); end
            total++; if (en !== 0) begin bad++; $display("FAIL flt_mem_en addr=%h got=%b exp=0", addrs[k], en); end
            total++; if (err !== 1) begin bad++; $display("FAIL flt_err addr=%h got=%b exp=1", addrs[k], err); end
            total++; if (rd !== 0) begin bad++; $display("FAIL flt_rdata addr=%h got=%h exp=0", addrs[k], rd); end
            total++; if (sb !== 0) begin bad++; $display("FAIL flt_stall addr=%h stall wrong", addrs[k]); end
        end
    endtask

    task automatic test_contention();
        logic got [10];
        logic exp_seq [10];
        int n = 0;
        exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        @(negedge clk);
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 32'h0;
        bus.b_req = 1; bus.b_we = 0; bus.b_addr = 32'h4;
        for (int c = 0; c < 40 && n < 10; c++) begin
            @(negedge clk);
            if (bus.a_ready && bus.b_ready) begin
                total++; bad++; $display("FAIL both_ready got=11 exp=one-hot");
            end
            if (bus.b_ready) begin
                total++; if (dut.cnt_q !== 0) begin bad++; $display("FAIL starve_clear got=%0d exp=0", dut.cnt_q); end
            end
            if (bus.a_ready || bus.b_ready) begin
                got[n] = bus.b_ready; n++;
            end
        end
        bus.a_req = 0; bus.b_req = 0;
        total++; if (n !== 10) begin bad++; $display("FAIL grant_count got=%0d exp=10", n); end
        for (int i = 0; i < n; i++) begin
            total++; if (got[i] !== exp_seq[i]) begin bad++; $display("FAIL grant_%0d got=%s exp=%s", i, got[i] ? "B" : "A", exp_seq[i] ? "B" : "A"); end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic err, en, we, sb; logic [4:0] ma;
        logic seen;
        run_txn(0, 1, 32'h4, 32'h11111111, lat, rd, err, en, we, ma, sb);
        total++; if (lat !== 2) begin bad++; $display("FAIL pre_write_latency got=%0d exp=2", lat); end
        @(negedge clk);
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 32'h4; bus.a_wdata = 32'h22222222;
        @(negedge clk);
        total++; if (bus.mem_en !== 1) begin bad++; $display("FAIL mid_access got=%b exp=1", bus.mem_en); end
        rst = 1; bus.a_req = 0;
        #1;
        total++; if (bus.mem_en !== 0 || bus.mem_we !== 0) begin bad++; $display("FAIL mid_gate got=%b%b exp=00", bus.mem_en, bus.mem_we); end
        @(negedge clk);
        rst = 0;
        seen = 0;
        repeat (4) begin @(negedge clk); if (bus.a_ready) seen = 1; end
        total++; if (seen !== 0) begin bad++; $display("FAIL mid_no_ready got=%b exp=0", seen); end
        total++; if (tbmem[1] !== 32'h11111111) begin bad++; $display("FAIL mid_word got=%h exp=11111111", tbmem[1]); end
        run_txn(0, 0, 32'h4, 32'h0, lat, rd, err, en, we, ma, sb);
        total++; if (lat !== 2 || rd !== 32'h11111111) begin bad++; $display("FAIL mid_readback got=%h/%0d exp=11111111/2", rd, lat); end
    endtask

    task automatic test_b_loader();
        int lat; logic [31:0] rd; logic err, en, we, sb; logic [4:0] ma;
        for (int unsigned i = 0; i < 32; i++) begin
            run_txn(1, 1, i * 4, pat(i), lat, rd, err, en, we, ma, sb);
            total++; if (lat !== 2 || err !== 0 || sb !== 0 || ma !== 5'(i)) begin
                bad++; $display("FAIL ldr_wr_%0d lat=%0d err=%b stall=%b idx=%0d exp=2/0/0/%0d", i, lat, err, sb, ma, i);
            end
        end
        for (int unsigned i = 0; i < 32; i++) begin
            run_txn(1, 0, i * 4, 32'h0, lat, rd, err, en, we, ma, sb);
            total++; if (rd !== pat(i) || lat !== 2 || sb !== 0) begin
                bad++; $display("FAIL ldr_rd_%0d got=%h exp=%h lat=%0d", i, rd, pat(i), lat);
            end
        end
    endtask

    initial begin
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
        test_reset();
        test_a_store_load();
        test_fault();
        test_contention();
        test_reset_mid();
        test_b_loader();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive port-A wins tolerated while port B waits.
REQ-002 Parameter ADDR_W, default 5: word-index width of the data memory (32 words).
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 a_req  in  1  pipeline MEM-stage request; held with fields stable until a_ready.
REQ-006 a_we  in  1  port A write (1) / read (0).
REQ-007 a_addr  in  32  port A byte address (ALU result).
REQ-008 a_wdata  in  32  port A store data.
REQ-009 a_rdata  out  32  port A load data, valid while a_ready=1.
REQ-010 a_ready  out  1  one-cycle completion pulse for port A.
REQ-011 a_err  out  1  port A address fault, valid with a_ready.
REQ-012 stall  out  1  pipeline freeze: a_req & ~a_ready.
REQ-013 b_req, b_we, b_addr[32], b_wdata[32]  in; b_rdata[32], b_ready, b_err  out: debug/loader port, same semantics as port A.
REQ-014 mem_en  out  1  memory access strobe.
REQ-015 mem_we  out  1  memory write strobe.
REQ-016 mem_addr  out  ADDR_W  word index.
REQ-017 mem_wdata  out  32  write data.
REQ-018 mem_rdata  in  32  memory read data, valid one cycle after mem_en (synchronous read).

Function
REQ-019 FSM states IDLE, ACCESS, RESP; transitions IDLE->ACCESS on any req, ACCESS->RESP always, RESP->IDLE always.
REQ-020 In IDLE, grant to A if a_req and not (b_req and starve_cnt==STARVE_MAX); else grant to B if b_req; owner, we, addr, wdata latched at the edge.
REQ-021 starve_cnt (width clog2(STARVE_MAX+1)): increments when A granted while b_req=1, saturates at STARVE_MAX, clears when B granted.
REQ-022 ACCESS: mem_en=1, mem_we=latched we, mem_addr=latched addr[ADDR_W+1:2], mem_wdata=latched wdata; all memory outputs 0 in other states.
REQ-023 RESP: owner's ready=1 for exactly one cycle; owner's rdata=mem_rdata for reads, 0 for writes; non-owner ready=0.
REQ-024 Latency: req seen in IDLE at cycle n -> mem_en at cycle n+1 -> ready at cycle n+2; peak throughput one access per 3 cycles.
REQ-025 Address fault: addr[1:0]!=0 or addr[31:ADDR_W+2]!=0 -> mem_en stays 0 in ACCESS; RESP pulses ready with err=1, rdata=0.
REQ-026 Requests deasserted before grant are dropped without side effects; req changes after grant are ignored until RESP.
REQ-027 Simultaneous a_req and b_req with starve_cnt<STARVE_MAX: A wins; at STARVE_MAX: B wins.
REQ-028 rdata outputs hold 0 when the corresponding ready=0.

Reset
REQ-029 While rst=1: state=IDLE, starve_cnt=0, all outputs 0, no grant latched.
REQ-030 mem_en and mem_we gated by ~rst, so an ACCESS cycle coinciding with rst issues no write.
REQ-031 Reset mid-transaction abandons it; no ready pulse follows; requester re-arbitrates after rst falls.

Structure
REQ-032 Package dmem_arb_pkg holds the state enumeration, default STARVE_MAX, default ADDR_W.
REQ-033 Sub-module dmem_addr_check (combinational: byte address -> word index, fault flag), one instance per port.
REQ-034 FSM, starvation counter and output registers reside in data_mem_arbiter; the memory array is external.

Verification
REQ-035 A-only: store a_addr=0x8, a_wdata=0xDEADBEEF, then load a_addr=0x8 -> mem_we at ACCESS with mem_addr=2; load a_rdata=0xDEADBEEF with a_ready at cycle n+2.
REQ-036 Contention: a_req and b_req held continuously -> grant order A,A,A,A,B,A... (B served after the 4th A win); starve_cnt returns to 0.
REQ-037 Fault: a_addr=0x6 and a_addr=0x80 -> no mem_en, a_ready with a_err=1, a_rdata=0; stall=1 until that pulse.
REQ-038 Reset in ACCESS of a write to 0x4 -> mem_we=0 that cycle; the word at index 1 is unchanged; no a_ready.
REQ-039 B-only loader: write words 0..31 (b_addr 0x0..0x7C) then read back -> all match; stall stays 0 throughout.
